uart_rx_fsm: RTL and testbench

//  Frame controller for the UART receiver. Detects the start edge on RX_IN and keeps the

---
 rtl/uart_rx_fsm.sv | 130 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame sequencer. It keeps the oversampling edge and bit
// counters, fires one-cycle check/shift strobes mid-bit, and qualifies each frame.
module uart_rx_fsm #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             RX_IN,
    input  logic                             PAR_EN,
    input  logic                             strt_glitch,
    input  logic                             par_err,
    input  logic                             stp_err,
    output logic [$clog2(PRESCALE)-1:0]      edge_cnt,
    output logic [$clog2(DATA_WIDTH+3)-1:0]  bit_cnt,
    output logic                             dat_samp_en,
    output logic                             strt_chk_en,
    output logic                             par_chk_en,
    output logic                             stp_chk_en,
    output logic                             deser_en,
    output logic                             data_valid,
    output logic                             framing_err,
    output logic                             parity_err
);
    localparam int EW  = $clog2(PRESCALE);
    localparam int BW  = $clog2(DATA_WIDTH + 3);
    localparam int CHK = PRESCALE / 2 + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t          r_state;
    logic [EW-1:0]   r_edge_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic            r_dat_samp_en;
    logic            r_strt_chk_en;
    logic            r_par_chk_en;
    logic            r_stp_chk_en;
    logic            r_deser_en;
    logic            r_data_valid;
    logic            r_framing_err;
    logic            r_parity_err;
    logic            r_par_en;
    logic            r_par_flag;
    logic            r_stp_flag;
    logic            w_wrap;
    logic            w_pre_chk;

    assign w_wrap    = r_edge_cnt == EW'(PRESCALE - 1);
    // Strobes are registered, so they are scheduled one edge ahead of CHK
    assign w_pre_chk = r_edge_cnt == EW'(CHK - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_edge_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_dat_samp_en <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            r_deser_en    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            r_parity_err  <= 1'b0;
            r_par_en      <= 1'b0;
            r_par_flag    <= 1'b0;
            r_stp_flag    <= 1'b0;
        end else begin
            r_strt_chk_en <= w_pre_chk && r_state == START;
            r_deser_en    <= w_pre_chk && r_state == DATA;
            r_par_chk_en  <= w_pre_chk && r_state == PARITY;
            r_stp_chk_en  <= w_pre_chk && r_state == STOP;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            r_parity_err  <= 1'b0;
            if (r_par_chk_en && par_err) r_par_flag <= 1'b1;
            if (r_stp_chk_en && stp_err) r_stp_flag <= 1'b1;
            r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + 1'b1;
            if (w_wrap) r_bit_cnt <= r_bit_cnt + 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    // DONE also accepts a start edge so frames can run back to back
                    r_edge_cnt    <= '0;
                    r_bit_cnt     <= '0;
                    r_par_flag    <= 1'b0;
                    r_stp_flag    <= 1'b0;
                    r_dat_samp_en <= !RX_IN;
                    r_state       <= RX_IN ? IDLE : START;
                    if (!RX_IN) r_par_en <= PAR_EN;
                end
                START: begin
                    if (r_strt_chk_en && strt_glitch) begin
                        r_state       <= IDLE;
                        r_dat_samp_en <= 1'b0;
                        r_edge_cnt    <= '0;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_wrap && r_bit_cnt == BW'(DATA_WIDTH)) r_state <= r_par_en ? PARITY : STOP;
                end
                PARITY: begin
                    if (w_wrap) r_state <= STOP;
                end
                default: begin
                    if (w_wrap) begin
                        r_state       <= DONE;
                        r_dat_samp_en <= 1'b0;
                        r_bit_cnt     <= '0;
                        r_data_valid  <= !r_par_flag && !r_stp_flag;
                        r_framing_err <= r_stp_flag;
                        r_parity_err  <= r_par_flag;
                    end
                end
            endcase
        end
    end

    assign edge_cnt    = r_edge_cnt;
    assign bit_cnt     = r_bit_cnt;
    assign dat_samp_en = r_dat_samp_en;
    assign strt_chk_en = r_strt_chk_en;
    assign par_chk_en  = r_par_chk_en;
    assign stp_chk_en  = r_stp_chk_en;
    assign deser_en    = r_deser_en;
    assign data_valid  = r_data_valid;
    assign framing_err = r_framing_err;
    assign parity_err  = r_parity_err;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scenario tasks drive whole frames with random side inputs and compare
// every cycle against a position-within-frame model of the receiver controller.
module tb_uart_rx_fsm;
    localparam int PS  = 8;
    localparam int DW  = 8;
    localparam int CHK = PS / 2 + 2;
    localparam int EW  = $clog2(PS);
    localparam int BW  = $clog2(DW + 3);

    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0;
    logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
    logic [EW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic data_valid, framing_err, parity_err;
    logic [14:0] obs;
    logic [14:0] obs_log [0:199];
    int n_pass = 0, n_total = 0, cyc = 0, st_cyc = 0;

    uart_rx_fsm #(.PRESCALE(PS), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .deser_en(deser_en), .data_valid(data_valid), .framing_err(framing_err),
        .parity_err(parity_err)
    );

    assign obs = {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
                  data_valid, framing_err, parity_err, bit_cnt, edge_cnt};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected outputs p cycles after START entry, from the frame layout alone
    function automatic logic [14:0] model(input int p, input bit par, input bit glitch,
                                          input bit perr, input bit serr, input bit b2b);
        int total, bi, ed;
        logic s, a, b, c, d, v, f, e;
        total = (DW + 2 + int'(par)) * PS;
        bi = 0;
        ed = 0;
        {s, a, b, c, d, v, f, e} = '0;
        if (glitch) begin
            if (p <= CHK) begin
                s = 1'b1;
                ed = p;
                a = p == CHK;
            end
        end else if (p < total) begin
            s = 1'b1;
            bi = p / PS;
            ed = p % PS;
            if (ed == CHK) begin
                a = bi == 0;
                d = bi >= 1 && bi <= DW;
                b = par && bi == DW + 1;
                c = bi == DW + 1 + int'(par);
            end
        end else if (p == total) begin
            v = !perr && !serr;
            f = serr;
            e = perr;
        end else if (b2b) begin
            s = 1'b1;
        end
        return {s, a, b, c, d, v, f, e, BW'(bi), EW'(ed)};
    endfunction

    // Drives one frame starting at the next clock edge; logs outputs per cycle
    task automatic play(input bit par, input bit glitch, input bit perr, input bit serr,
                        input bit b2b, input logic [7:0] data, input int stop_at, output int n);
        int total, bi, ed;
        total = (DW + 2 + int'(par)) * PS;
        n = glitch ? CHK + 3 : total + (b2b ? 0 : 1);
        if (stop_at < n) n = stop_at;
        RX_IN = 1'b0;
        PAR_EN = par;
        for (int p = 0; p <= n; p++) begin
            @(posedge CLK);
            #1;
            if (p == 0) st_cyc = cyc;
            bi = p / PS;
            ed = p % PS;
            if (glitch) RX_IN = p >= 2;
            else RX_IN = bi == 0 ? 1'b0 : bi <= DW ? data[bi-1] : (par && bi == DW + 1) ? ^data : 1'b1;
            PAR_EN = 1'($urandom);
            strt_glitch = (ed == CHK && bi == 0) ? glitch : 1'($urandom);
            par_err = (ed == CHK && bi == DW + 1 && par) ? perr : 1'($urandom);
            stp_err = (ed == CHK && bi == DW + 1 + int'(par)) ? serr : 1'($urandom);
            @(negedge CLK);
            obs_log[p] = obs;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        n_total++;
        if (obs !== '0) $display("FAIL reset_hold got %h exp 0", obs); else n_pass++;
        RX_IN = 1'b0;
        @(negedge CLK);
        n_total++;
        if (obs !== '0) $display("FAIL reset_rx_low got %h exp 0", obs); else n_pass++;
        RX_IN = 1'b1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_total++;
        if (obs !== '0) $display("FAIL idle got %h exp 0", obs); else n_pass++;
    endtask

    task automatic test_clean_frame;
        int n, nd, nv, pv;
        nd = 0; nv = 0; pv = -1;
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0))
                $display("FAIL clean p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            else n_pass++;
            if (obs_log[p][10] && obs_log[p][2:0] == 3'(CHK)) nd++;
            if (obs_log[p][9]) begin nv++; pv = p; end
        end
        n_total++;
        if (nd !== DW) $display("FAIL clean_deser got %0d exp %0d", nd, DW); else n_pass++;
        n_total++;
        if (nv !== 1) $display("FAIL clean_dv_count got %0d exp 1", nv); else n_pass++;
        n_total++;
        if (pv !== (DW + 2) * PS) $display("FAIL clean_latency got %0d exp %0d", pv, (DW + 2) * PS); else n_pass++;
    endtask

    task automatic test_glitch;
        int n, nd, nv;
        nd = 0; nv = 0;
        play(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0))
                $display("FAIL glitch p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            else n_pass++;
            if (obs_log[p][10]) nd++;
            if (obs_log[p][9]) nv++;
        end
        n_total++;
        if (nd !== 0 || nv !== 0) $display("FAIL glitch_quiet got deser=%0d dv=%0d exp 0 0", nd, nv); else n_pass++;
    endtask

    task automatic test_parity_err;
        int n, pe, nv;
        pe = -1; nv = 0;
        play(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0))
                $display("FAIL par p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            else n_pass++;
            if (obs_log[p][7]) pe = p;
            if (obs_log[p][9]) nv++;
        end
        n_total++;
        if (pe !== (DW + 3) * PS || nv !== 0) $display("FAIL par_pulse got at=%0d dv=%0d exp %0d 0", pe, nv, (DW + 3) * PS); else n_pass++;
    endtask

    task automatic test_framing_err;
        int n, nf, nv;
        bit par;
        nf = 0; nv = 0;
        par = 1'($urandom);
        play(par, 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, par, 1'b0, 1'b0, 1'b1, 1'b0))
                $display("FAIL stp p=%0d got %h exp %h", p, obs_log[p], model(p, par, 1'b0, 1'b0, 1'b1, 1'b0));
            else n_pass++;
            if (obs_log[p][8]) nf++;
            if (obs_log[p][9]) nv++;
        end
        n_total++;
        if (nf !== 1 || nv !== 0) $display("FAIL stp_pulse got fe=%0d dv=%0d exp 1 0", nf, nv); else n_pass++;
        nv = 0;
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0))
                $display("FAIL after_stp p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            else n_pass++;
            if (obs_log[p][9]) nv++;
        end
        n_total++;
        if (nv !== 1) $display("FAIL after_stp_dv got %0d exp 1", nv); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        int n, pv;
        pv = -1;
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 4 * PS + 3, n);
        #2 RST = 1'b1;
        #1;
        n_total++;
        if (obs !== '0) $display("FAIL rst_async got %h exp 0", obs); else n_pass++;
        RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_total++;
        if (obs !== '0) $display("FAIL rst_idle got %h exp 0", obs); else n_pass++;
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) if (obs_log[p][9]) pv = p;
        n_total++;
        if (pv !== (DW + 2) * PS) $display("FAIL rst_next_dv got %0d exp %0d", pv, (DW + 2) * PS); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n, dv1, dv2;
        dv1 = -1; dv2 = -1;
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1))
                $display("FAIL b2b1 p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            else n_pass++;
            if (obs_log[p][9]) dv1 = st_cyc + p;
        end
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 999, n);
        for (int p = 0; p <= n; p++) begin
            n_total++;
            if (obs_log[p] !== model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0))
                $display("FAIL b2b2 p=%0d got %h exp %h", p, obs_log[p], model(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            else n_pass++;
            if (obs_log[p][9]) dv2 = st_cyc + p;
        end
        n_total++;
        if (dv2 - dv1 !== (DW + 2) * PS + 1) $display("FAIL b2b_gap got %0d exp %0d", dv2 - dv1, (DW + 2) * PS + 1); else n_pass++;
    endtask

    task automatic test_random;
        int n;
        bit par, gl, pe, se;
        for (int k = 0; k < 8; k++) begin
            par = 1'($urandom);
            gl = $urandom_range(0, 3) == 0;
            pe = par && 1'($urandom);
            se = 1'($urandom);
            play(par, gl, pe, se, 1'b0, 8'($urandom), 999, n);
            for (int p = 0; p <= n; p++) begin
                n_total++;
                if (obs_log[p] !== model(p, par, gl, pe, se, 1'b0))
                    $display("FAIL rand k=%0d p=%0d got %h exp %h", k, p, obs_log[p], model(p, par, gl, pe, se, 1'b0));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_clean_frame;
        test_glitch;
        test_parity_err;
        test_framing_err;
        test_reset_mid_frame;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
